usart_tx_buffered: RTL and testbench
====================================

# usart_tx_buffered

Buffered asynchronous serial transmitter: accepts bytes over a valid/ready handshake into a small FIFO and shifts them out on `tx_pin` as 8N1 frames (LSB first) at a programmable bit period. It is the transmit half of the USART library and pairs with the existing USART receive path, which samples the same frame format. The FIFO lets a host burst several bytes without waiting on the line.

## Interface
- `FIFO_DEPTH`, 4: FIFO entries; must be a power of two, at least 2.
- `FIFO_ADDR_BITS`, 2: log2(`FIFO_DEPTH`).
- `comm_clock` input 1: sole clock; all logic on rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `clocks_per_bit` input 12: bit period in `comm_clock` cycles. Latched at each frame start. Values 0 and 1 are treated as 2.
- `data_in` input 8: byte to transmit.
- `data_valid` input 1: `data_in` is valid this cycle.
- `data_ready` output 1: FIFO can accept a byte; combinational, equal to `fifo_count != FIFO_DEPTH`.
- `tx_pin` output 1: serial line, idle high; registered.
- `busy` output 1: high while a frame is on the line (START, DATA or STOP); registered.
- `fifo_count` output `FIFO_ADDR_BITS+1`: number of bytes queued; the byte being shifted is not counted.

## Operation
- **Push:** a write occurs at a rising edge when `data_valid && data_ready && reset_n`. `data_in` is written at the write pointer, and the pointer increments modulo `FIFO_DEPTH`.
- **Pop:** occurs when the FSM leaves IDLE or STOP to start a frame. The read pointer increments modulo `FIFO_DEPTH`, and the byte loads the shift register.
- **Count:** `fifo_count` is +1 on a push only, -1 on a pop only, and unchanged on a simultaneous push and pop.
- **Full:** `data_ready` is 0 while full, even if a pop occurs the same cycle. A valid byte offered while full is not accepted and not lost from the FIFO. The host holds it.
- **FSM states:** IDLE, START, DATA, STOP. A bit-timer counts down from `clocks_per_bit_latched-1`, and a 3-bit index tracks the data bit.
  - **IDLE:** `tx_pin`=1, `busy`=0. If `fifo_count>0`: pop, latch `clocks_per_bit` (clamped to ≥2), drive `tx_pin`=0, go to START.
  - **START:** `tx_pin`=0 for N cycles. Then drive `tx_pin`=shift[0], index=0, go to DATA.
  - **DATA:** each bit is held N cycles, then the register shifts right and the index increments. After bit 7's N cycles: `tx_pin`=1, go to STOP.
  - **STOP:** `tx_pin`=1 for N cycles. At the end, if `fifo_count>0`, pop and start the next frame directly (`tx_pin`=0, START) with no idle gap. Otherwise go to IDLE.
- **Latched period:** changes to `clocks_per_bit` mid-frame have no effect until the next frame start.
- **Reset:** `reset_n` low at an edge forces IDLE, `tx_pin`=1, `busy`=0, pointers and count to 0, and timer and index to 0. It does this mid-frame too, truncating the frame. FIFO contents are discarded; the storage array itself needs no reset.
- **Reset output values:** `tx_pin`=1, `busy`=0, `fifo_count`=0, `data_ready`=1. Writes are ignored while `reset_n`=0.

## Timing
- **Push to line:** a push at edge E into an empty, idle block takes effect as follows.
  - Edge E: `fifo_count`=1.
  - Edge E+1: pop, so `fifo_count`=0, and `tx_pin` falls and `busy` rises.
- **Frame length:** exactly 10·N cycles from the `tx_pin` falling edge to the end of the stop bit. Each bit lasts exactly N cycles.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the stop bit's Nth cycle, giving continuous 10·N periodicity.
- **Throughput:** one byte per 10·N cycles. Up to `FIFO_DEPTH` bytes are queued plus one in the shift register.
- **`busy` timing:** `busy` falls on the same edge `tx_pin` would start an idle cycle, i.e. N cycles after the stop bit begins when the FIFO is empty.

## Test plan
- **Single byte:** reset 4 cycles, N=32, push 0x75 once.
  - `tx_pin` low at E+1 for 32 cycles.
  - Data bits 1,0,1,0,1,1,1,0 at 32 cycles each.
  - High for stop, then `busy`=0 at E+1+320.
- **Back-to-back bytes:** push 0x75 then 0x8A on consecutive cycles, N=32.
  - Second start bit begins exactly 320 cycles after the first.
  - Second frame's data bits are 0,1,0,1,0,0,0,1.
  - `fifo_count` sequence 1,1,0 around the pops.
- **FIFO full:** hold `data_valid`=1 with bytes 0x01..0x06 while transmitting, N=2.
  - `data_ready` drops when `fifo_count`=4.
  - Each byte appears on `tx_pin` exactly once and in order; none is lost.
- **Period clamp and latch:** `clocks_per_bit`=0 gives 2-cycle bits.
  - Change `clocks_per_bit` from 8 to 16 mid-frame.
  - The current frame stays at 8-cycle bits; the next frame uses 16.
- **Reset mid-frame:** assert `reset_n`=0 for 1 cycle during DATA with 3 bytes queued.
  - Next edge: `tx_pin`=1, `busy`=0, `fifo_count`=0.
  - No further frames follow without new pushes.
- **Loopback:** wire `tx_pin` to the USART receiver at matching bit rate and send 0x00, 0xFF, 0x55.
  - Receiver reports the identical bytes.

Source files
------------

// File: rtl/usart_tx_buffered.sv
// usart_tx_buffered: FIFO-buffered 8N1 serial transmitter with a per-frame latched bit period.
module usart_tx_buffered #(
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_ADDR_BITS = 2
) (
  input  logic                    comm_clock,
  input  logic                    reset_n,
  input  logic [11:0]             clocks_per_bit,
  input  logic [7:0]              data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic                    tx_pin,
  output logic                    busy,
  output logic [FIFO_ADDR_BITS:0] fifo_count
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam logic [FIFO_ADDR_BITS:0] LP_FULL = (FIFO_ADDR_BITS+1)'(FIFO_DEPTH);
  logic [7:0]                r_mem [FIFO_DEPTH];
  logic [FIFO_ADDR_BITS-1:0] r_wr, r_rd;
  logic [FIFO_ADDR_BITS:0]   r_count;
  state_t                    r_state;
  logic [11:0]               r_timer, r_n;
  logic [7:0]                r_shift;
  logic [2:0]                r_idx;
  logic                      r_tx, r_busy;
  logic                      w_push, w_pop, w_tdone;
  logic [11:0]               w_cpb;
  assign data_ready = r_count != LP_FULL;
  assign fifo_count = r_count;
  assign tx_pin     = r_tx;
  assign busy       = r_busy;
  assign w_push     = data_valid && data_ready;
  assign w_tdone    = r_timer == 12'd0;
  assign w_pop      = (r_state == S_IDLE || (r_state == S_STOP && w_tdone)) && r_count != '0;
  assign w_cpb      = clocks_per_bit < 12'd2 ? 12'd2 : clocks_per_bit;
  always_ff @(posedge comm_clock)
    if (reset_n && w_push) r_mem[r_wr] <= data_in;
  always_ff @(posedge comm_clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_timer <= '0;
      r_idx   <= '0;
      r_n     <= 12'd2;
      r_shift <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= (w_push && !w_pop) ? r_count + 1'b1 : (w_pop && !w_push) ? r_count - 1'b1 : r_count;
      // A pop always starts a fresh frame, whether from IDLE or straight out of STOP
      if (w_pop) begin
        r_state <= S_START;
        r_tx    <= 1'b0;
        r_busy  <= 1'b1;
        r_shift <= r_mem[r_rd];
        r_n     <= w_cpb;
        r_timer <= w_cpb - 12'd1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
          end
          S_START:
            if (w_tdone) begin
              r_state <= S_DATA;
              r_tx    <= r_shift[0];
              r_idx   <= '0;
              r_timer <= r_n - 12'd1;
            end else r_timer <= r_timer - 12'd1;
          S_DATA:
            if (w_tdone) begin
              r_timer <= r_n - 12'd1;
              if (r_idx == 3'd7) begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end else begin
                r_shift <= r_shift >> 1;
                r_tx    <= r_shift[1];
                r_idx   <= r_idx + 3'd1;
              end
            end else r_timer <= r_timer - 12'd1;
          S_STOP:
            if (w_tdone) begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end else r_timer <= r_timer - 12'd1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_usart_tx_buffered.sv
// tb_usart_tx_buffered: frame-level reference model plus table-driven loopback and corner sequences.
module tb_usart_tx_buffered;
  localparam int DEPTH = 4;
  logic        clk = 0, rst_n = 0, valid = 0;
  logic [11:0] cpb = 12'd4;
  logic [7:0]  din = 0;
  logic        ready, tx, busy;
  logic [2:0]  cnt;
  int n_chk = 0, n_pass = 0;

  usart_tx_buffered #(.FIFO_DEPTH(DEPTH), .FIFO_ADDR_BITS(2)) dut (
    .comm_clock(clk), .reset_n(rst_n), .clocks_per_bit(cpb), .data_in(din),
    .data_valid(valid), .data_ready(ready), .tx_pin(tx), .busy(busy), .fifo_count(cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: a frame is a start time and a period; the line value is derived from elapsed time
  int        cyc = 0, m_start = 0, m_n = 2;
  logic [7:0] q[$];
  logic [7:0] m_byte = 0;
  bit        m_act = 0, m_acc = 0, mon_en = 0;
  always @(posedge clk) begin
    int sz;
    bit fin, pop;
    cyc++;
    m_acc = 0;
    if (!rst_n) begin
      q.delete();
      m_act = 0;
    end else begin
      sz  = q.size();
      fin = m_act && (cyc == m_start + 10 * m_n);
      pop = (!m_act || fin) && sz > 0;
      if (fin && !pop) m_act = 0;
      if (pop) begin
        m_byte  = q.pop_front();
        m_start = cyc;
        m_n     = cpb < 2 ? 2 : int'(cpb);
        m_act   = 1;
      end
      if (valid && sz < DEPTH) begin
        q.push_back(din);
        m_acc = 1;
      end
    end
  end

  always @(negedge clk) if (mon_en) begin
    int k;
    logic etx;
    k   = (cyc - m_start) / m_n;
    etx = !m_act ? 1'b1 : k == 0 ? 1'b0 : k == 9 ? 1'b1 : m_byte[k-1];
    chk("model_tx", tx, etx);
    chk("model_busy", busy, m_act);
    chk("model_count", cnt, q.size());
    chk("model_ready", ready, q.size() != DEPTH);
  end

  task automatic push(input logic [7:0] d);
    valid = 1; din = d;
    @(negedge clk);
    valid = 0;
  endtask

  task automatic wait_idle(input int lim);
    int t = 0;
    while ((busy !== 1'b0 || cnt !== 0) && t < lim) begin @(negedge clk); t++; end
    chk("idle_timeout", t < lim, 1);
  endtask

  typedef struct { logic [7:0] d; logic [11:0] cpb; int n; } vec_t;
  vec_t vt[6];

  initial begin
    vt[0] = '{8'h75, 12'd32, 32};
    vt[1] = '{8'h00, 12'd0, 2};
    vt[2] = '{8'hFF, 12'd1, 2};
    vt[3] = '{8'h55, 12'd5, 5};
    vt[4] = '{8'h8A, 12'd3, 3};
    vt[5] = '{8'hC3, 12'd2, 2};
    repeat (4) @(negedge clk);
    rst_n = 1;
    mon_en = 1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", cnt, 0);
    chk("rst_ready", ready, 1);

    // Loopback receiver sampling each bit inside its period
    foreach (vt[r]) begin
      int t;
      logic [7:0] rx;
      cpb = vt[r].cpb;
      push(vt[r].d);
      t = 0;
      while (tx !== 1'b0 && t < 5) begin @(negedge clk); t++; end
      chk("rx_start_seen", t < 5, 1);
      for (int i = 0; i < 8; i++) begin
        repeat (vt[r].n) @(negedge clk);
        rx[i] = tx;
      end
      repeat (vt[r].n) @(negedge clk);
      chk("rx_stop", tx, 1);
      chk("rx_byte", rx, vt[r].d);
      t = 9 * vt[r].n;
      while (busy === 1'b1 && t < 10 * vt[r].n + 10) begin @(negedge clk); t++; end
      chk("frame_len", t, 10 * vt[r].n);
    end
    wait_idle(50);

    // Push-to-line latency and busy fall
    cpb = 12'd32;
    push(8'h75);
    chk("e_count1", cnt, 1);
    @(negedge clk);
    chk("e1_count0", cnt, 0);
    chk("e1_tx_low", tx, 0);
    chk("e1_busy", busy, 1);
    repeat (319) @(negedge clk);
    chk("busy_before_end", busy, 1);
    @(negedge clk);
    chk("busy_fall", busy, 0);
    wait_idle(20);

    // Back-to-back frames with no idle gap
    valid = 1; din = 8'h75;
    @(negedge clk);
    din = 8'h8A;
    chk("b2b_count_a", cnt, 1);
    @(negedge clk);
    valid = 0;
    chk("b2b_count_b", cnt, 1);
    repeat (319) @(negedge clk);
    chk("b2b_stop", tx, 1);
    @(negedge clk);
    chk("b2b_start2", tx, 0);
    chk("b2b_count_c", cnt, 0);
    wait_idle(400);

    // Host holds bytes while the FIFO is full
    cpb = 12'd2;
    begin
      int i = 1, t = 0;
      bit saw_full = 0;
      valid = 1; din = 8'd1;
      while (i <= 6 && t < 400) begin
        @(negedge clk); t++;
        if (cnt === 3'd4) begin saw_full = 1; chk("full_ready", ready, 0); end
        if (m_acc) begin i++; din = 8'(i); end
      end
      valid = 0;
      chk("full_all_taken", i, 7);
      chk("full_seen", saw_full, 1);
    end
    wait_idle(200);

    // Period latched at frame start
    cpb = 12'd8;
    push(8'h3C);
    push(8'hA5);
    repeat (20) @(negedge clk);
    cpb = 12'd16;
    wait_idle(400);

    // Reset mid-frame with bytes queued
    cpb = 12'd4;
    valid = 1;
    for (int i = 0; i < 4; i++) begin din = 8'h10 + 8'(i); @(negedge clk); end
    valid = 0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", cnt, 0);
    rst_n = 1;
    repeat (100) @(negedge clk);
    chk("post_rst_quiet", busy, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      valid = ($urandom % 4) == 0;
      din = 8'($urandom);
      if (($urandom % 200) == 0) cpb = 12'($urandom_range(0, 5));
      @(negedge clk);
    end
    valid = 0;
    wait_idle(1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
